// File: rtl/reset_sequencer.sv
// reset_sequencer: SoC reset source. It holds reset until the PLL has been locked for
// LOCK_DELAY cycles, re-asserts reset when lock is lost, and issues a stretched reset
// pulse when the debounced GRESET button is released. The last reset cause is kept
// in io_cause for firmware.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_LOCK | reset held, waiting for the synchronised PLL lock
// LOCK_WAIT | reset held, counting LOCK_DELAY cycles of stable lock
// RUN       | reset released, watching for lock loss or a button release
// PULSE     | reset held for PULSE_CYCLES after a button release
module reset_sequencer #(
  parameter int LOCK_DELAY      = 255,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int PULSE_CYCLES    = 16,
  parameter int CNT_WIDTH       = 16
) (
  input  logic       io_mainClk,
  input  logic       io_asyncResetn,
  input  logic       io_pllLocked,
  input  logic       io_button,
  output logic       io_reset,
  output logic [1:0] io_cause
);

  localparam logic [CNT_WIDTH-1:0] LOCK_TC  = CNT_WIDTH'(LOCK_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] DEB_TC   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] PULSE_TC = CNT_WIDTH'(PULSE_CYCLES - 1);

  localparam logic [1:0] CAUSE_POR    = 2'b00;
  localparam logic [1:0] CAUSE_LOCK   = 2'b01;
  localparam logic [1:0] CAUSE_BUTTON = 2'b10;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    LOCK_WAIT = 2'd1,
    RUN       = 2'd2,
    PULSE     = 2'd3
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] dcnt;
  logic [1:0]           lock_sync;
  logic [1:0]           btn_sync;
  logic                 btn_deb;
  logic                 btn_deb_d;
  logic                 lock_s;
  logic                 btn_s;
  logic                 fall;

  assign lock_s = lock_sync[1];
  assign btn_s  = btn_sync[1];

  // Debounced button went 1 -> 0 last cycle: one-cycle release strobe.
  assign fall = btn_deb_d & ~btn_deb;

  // Two-flop synchronisers for the asynchronous lock and button inputs.
  always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      lock_sync <= 2'b00;
      btn_sync  <= 2'b00;
    end else begin
      lock_sync <= {lock_sync[0], io_pllLocked};
      btn_sync  <= {btn_sync[0], io_button};
    end
  end

  // Accept a button level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      dcnt      <= '0;
      btn_deb   <= 1'b0;
      btn_deb_d <= 1'b0;
    end else begin
      btn_deb_d <= btn_deb;
      if (btn_s == btn_deb) begin
        dcnt <= '0;
      end else if (dcnt == DEB_TC) begin
        btn_deb <= btn_s;
        dcnt    <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

  // Sequencing FSM; io_reset and io_cause are registered here. Lock loss wins over
  // a button release, and a release outside RUN is dropped rather than queued.
  always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      state    <= WAIT_LOCK;
      cnt      <= '0;
      io_reset <= 1'b1;
      io_cause <= CAUSE_POR;
    end else begin
      case (state)
        WAIT_LOCK: begin
          cnt      <= '0;
          io_reset <= 1'b1;
          if (lock_s) state <= LOCK_WAIT;
        end
        LOCK_WAIT: begin
          io_reset <= 1'b1;
          if (!lock_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == LOCK_TC) begin
            state    <= RUN;
            cnt      <= '0;
            io_reset <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          cnt      <= '0;
          io_reset <= 1'b0;
          if (!lock_s) begin
            state    <= WAIT_LOCK;
            io_cause <= CAUSE_LOCK;
            io_reset <= 1'b1;
          end else if (fall) begin
            state    <= PULSE;
            io_cause <= CAUSE_BUTTON;
            io_reset <= 1'b1;
          end
        end
        PULSE: begin
          io_reset <= 1'b1;
          if (!lock_s) begin
            state    <= WAIT_LOCK;
            io_cause <= CAUSE_LOCK;
            cnt      <= '0;
          end else if (cnt == PULSE_TC) begin
            state    <= RUN;
            cnt      <= '0;
            io_reset <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state    <= WAIT_LOCK;
          cnt      <= '0;
          io_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule
